// File: rtl/bloco_controle.sv
// Sequencer for the polynomial datapath: steps X/H/S loads, operand muxes and ULA op
// to evaluate A*K*K + B*K + C (op=0) or A*K + B (op=1), one datapath step per cycle.
module bloco_controle #(
  parameter logic ULA_ADD = 1'b0,
  parameter logic ULA_MUL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       op,
  output logic       busy,
  output logic       done,
  output logic       LX,
  output logic       LH,
  output logic       LS,
  output logic [1:0] M0,
  output logic [1:0] M1,
  output logic [1:0] M2,
  output logic       H
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOADX = 3'd1;
  localparam logic [2:0] MUL_A = 3'd2;
  localparam logic [2:0] ADD_B = 3'd3;
  localparam logic [2:0] MUL_X = 3'd4;
  localparam logic [2:0] ADD_C = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  logic [2:0] state;
  logic [2:0] nextState;
  logic       opR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      opR   <= 1'b0;
    end else begin
      state <= nextState;
      if (state == IDLE && start) opR <= op;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = start ? LOADX : IDLE;
      LOADX:   nextState = MUL_A;
      MUL_A:   nextState = ADD_B;
      ADD_B:   nextState = opR ? DONE : MUL_X;
      MUL_X:   nextState = ADD_C;
      ADD_C:   nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Moore decode: every output is a function of state (and the captured op) only.
  always_comb begin
    busy = (state != IDLE);
    done = 1'b0;
    LX   = 1'b0;
    LH   = 1'b0;
    LS   = 1'b0;
    M0   = 2'b00;
    M1   = 2'b00;
    M2   = 2'b00;
    H    = ULA_ADD;
    case (state)
      LOADX: LX = 1'b1;
      MUL_A: begin
        M0 = 2'b01;
        H  = ULA_MUL;
        LH = 1'b1;
      end
      ADD_B: begin
        M0 = 2'b10;
        M2 = 2'b11;
        if (opR) LS = 1'b1;
        else     LH = 1'b1;
      end
      MUL_X: begin
        M1 = 2'b01;
        M2 = 2'b11;
        H  = ULA_MUL;
        LH = 1'b1;
      end
      ADD_C: begin
        M0 = 2'b11;
        M2 = 2'b11;
        LS = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bloco_controle.sv
// Bench for bloco_controle: drives a behavioural 16-bit datapath from the controller outputs
// and compares against per-step output tables and the closed-form polynomial.
module tb_bloco_controle;

  logic        clk = 1'b0;
  logic        rst, start, op;
  logic        busy, done, LX, LH, LS, H;
  logic [1:0]  M0, M1, M2;
  logic [15:0] A, B, C, K;
  logic [15:0] xReg, hReg, sReg;
  logic [15:0] m0v, av, bv, ulaV;
  logic [11:0] outs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bloco_controle #(.ULA_ADD(1'b0), .ULA_MUL(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .busy(busy), .done(done), .LX(LX), .LH(LH), .LS(LS),
    .M0(M0), .M1(M1), .M2(M2), .H(H)
  );

  assign outs = {busy, done, LX, LH, LS, M0, M1, M2, H};

  // Datapath as described by the mux/ULA encodings.
  always_comb begin
    case (M0)
      2'b00: m0v = 16'd0;
      2'b01: m0v = A;
      2'b10: m0v = B;
      default: m0v = C;
    endcase
    case (M1)
      2'b00: bv = m0v;
      2'b01: bv = xReg;
      2'b10: bv = sReg;
      default: bv = hReg;
    endcase
    case (M2)
      2'b00: av = xReg;
      2'b01: av = m0v;
      2'b10: av = sReg;
      default: av = hReg;
    endcase
    ulaV = H ? 16'(av * bv) : 16'(av + bv);
  end

  always_ff @(posedge clk) begin
    if (LX) xReg <= K;
    if (LH) hReg <= ulaV;
    if (LS) sReg <= ulaV;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] polyModel(input logic o, input logic [15:0] a, b, c, k);
    longint unsigned r;
    if (o) r = longint'(a) * k + b;
    else   r = longint'(a) * k * k + longint'(b) * k + c;
    return 16'(r % 65536);
  endfunction

  function automatic logic [11:0] mkv(input logic bz, dn, lx, lh, ls,
                                      input logic [1:0] m0, m1, m2, input logic h);
    return {bz, dn, lx, lh, ls, m0, m1, m2, h};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one sequence from IDLE; returns cycles from accept to done (20 = timed out).
  task automatic runSeq(input logic o, input logic [15:0] a, b, c, k, output int lat);
    A = a; B = b; C = c; K = k;
    op = o; start = 1'b1;
    tick();
    start = 1'b0;
    op = ~o;
    lat = 1;
    while (!done && lat < 20) begin
      check("oneLoad", 32'(LX + LH + LS), 32'(busy ? 1 : 0));
      tick();
      lat++;
    end
    check("doneNoLoad", 32'(LX + LH + LS), 32'd0);
    tick();
  endtask

  typedef struct {
    logic        op;
    int          step;
    logic [11:0] exp;
    logic        chkS;
    logic [15:0] expS;
  } vecT;

  vecT tbl[10];

  initial begin
    int lat;
    logic [15:0] prevS, ra, rb, rc, rk;
    logic ro;

    tbl[0] = '{1'b0, 1, mkv(1,0,1,0,0,2'b00,2'b00,2'b00,0), 1'b0, 16'd0};
    tbl[1] = '{1'b0, 2, mkv(1,0,0,1,0,2'b01,2'b00,2'b00,1), 1'b0, 16'd0};
    tbl[2] = '{1'b0, 3, mkv(1,0,0,1,0,2'b10,2'b00,2'b11,0), 1'b0, 16'd0};
    tbl[3] = '{1'b0, 4, mkv(1,0,0,1,0,2'b00,2'b01,2'b11,1), 1'b0, 16'd0};
    tbl[4] = '{1'b0, 5, mkv(1,0,0,0,1,2'b11,2'b00,2'b11,0), 1'b0, 16'd0};
    tbl[5] = '{1'b0, 6, mkv(1,1,0,0,0,2'b00,2'b00,2'b00,0), 1'b1, 16'd69};
    tbl[6] = '{1'b1, 1, mkv(1,0,1,0,0,2'b00,2'b00,2'b00,0), 1'b0, 16'd0};
    tbl[7] = '{1'b1, 2, mkv(1,0,0,1,0,2'b01,2'b00,2'b00,1), 1'b0, 16'd0};
    tbl[8] = '{1'b1, 3, mkv(1,0,0,0,1,2'b10,2'b00,2'b11,0), 1'b0, 16'd0};
    tbl[9] = '{1'b1, 4, mkv(1,1,0,0,0,2'b00,2'b00,2'b00,0), 1'b1, 16'd13};

    rst = 1'b1; start = 1'b0; op = 1'b0;
    A = 16'd2; B = 16'd3; C = 16'd4; K = 16'd5;
    tick();
    tick();
    check("resetOuts", 32'(outs), 32'd0);
    check("resetBusy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    check("idleOuts", 32'(outs), 32'd0);

    // Per-step output pattern for both ops, A=2 B=3 C=4 K=5.
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].step == 1) begin
        if (busy) tick();
        check("idleBeforeStart", 32'(outs), 32'd0);
        start = 1'b1; op = tbl[i].op;
        tick();
        start = 1'b0; op = ~tbl[i].op;
      end else begin
        tick();
      end
      check($sformatf("vec%0d", i), 32'(outs), 32'(tbl[i].exp));
      if (tbl[i].chkS) check($sformatf("vecS%0d", i), 32'(sReg), 32'(tbl[i].expS));
    end
    tick();
    check("afterTableIdle", 32'(outs), 32'd0);
    check("resultHeld", 32'(sReg), 32'd13);

    // Wrap-around case.
    runSeq(1'b0, 16'd2, 16'd0, 16'd0, 16'd255, lat);
    check("wrapLat", 32'(lat), 32'd6);
    check("wrapS", 32'(sReg), 32'hFC02);

    // Start held high: one accept per sequence, an IDLE cycle in between, op changes ignored.
    A = 16'd2; B = 16'd3; C = 16'd4; K = 16'd5;
    op = 1'b0; start = 1'b1;
    tick();
    lat = 1;
    while (!done && lat < 20) begin
      op = ~op;
      tick();
      lat++;
    end
    check("heldLat", 32'(lat), 32'd6);
    check("heldS", 32'(sReg), 32'd69);
    op = 1'b1;
    tick();
    check("heldIdleGap", 32'(busy), 32'd0);
    tick();
    check("heldReaccept", 32'(outs), 32'(mkv(1,0,1,0,0,2'b00,2'b00,2'b00,0)));
    start = 1'b0; op = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check("heldLat2", 32'(lat), 32'd4);
    check("heldS2", 32'(sReg), 32'd13);
    tick();

    // Reset in MUL_X abandons the sequence without a done pulse and leaves S alone.
    prevS = sReg;
    A = 16'd7; B = 16'd9; C = 16'd11; K = 16'd13;
    op = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("inMulX", 32'(outs), 32'(mkv(1,0,0,1,0,2'b00,2'b01,2'b11,1)));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstMidOuts", 32'(outs), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("rstNoDone", 32'(done), 32'd0);
      check("rstSHeld", 32'(sReg), 32'(prevS));
      tick();
    end
    runSeq(1'b0, 16'd7, 16'd9, 16'd11, 16'd13, lat);
    check("postRstLat", 32'(lat), 32'd6);
    check("postRstS", 32'(sReg), 32'd1311);

    // Random operands against the closed-form model.
    for (int n = 0; n < 25; n++) begin
      ro = 1'($urandom);
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 16'($urandom); rk = 16'($urandom);
      runSeq(ro, ra, rb, rc, rk, lat);
      check("randLat", 32'(lat), ro ? 32'd4 : 32'd6);
      check("randS", 32'(sReg), 32'(polyModel(ro, ra, rb, rc, rk)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
